// File: rtl/minterm_scan_pkg.sv
// Shared definitions for the minterm scanner: state encoding and minterm-count helpers.
package minterm_scan_pkg;

  localparam int NVARS_DFLT = 4;
  localparam int NMINTERMS  = 1 << NVARS_DFLT;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int nminterms(input int nvars);
    return 1 << nvars;
  endfunction

endpackage

// File: rtl/minterm_scan.sv
// Sweeps every input vector into an external combinational function, captures its
// truth table as a minterm mask, then streams the set minterm indices over valid/ready.
module minterm_scan
  import minterm_scan_pkg::*;
#(
  parameter int NVARS  = NVARS_DFLT,
  parameter int SETTLE = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [NVARS-1:0]             vars_out,
  input  logic                         y_in,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NVARS-1:0]             m_index,
  output logic [nminterms(NVARS)-1:0]  mask_out,
  output logic [NVARS:0]               count,
  output logic                         busy,
  output logic                         done
);

  localparam int NM = nminterms(NVARS);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [NVARS-1:0] LAST_IDX  = {NVARS{1'b1}};
  localparam logic [CW-1:0]    SETTLE_LD = CW'(SETTLE);

  logic [1:0]       state_q,    state_d;
  logic [NVARS-1:0] idx_q,      idx_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [NVARS-1:0] vars_out_q, vars_out_d;
  logic             m_valid_q,  m_valid_d;
  logic [NVARS-1:0] m_index_q,  m_index_d;
  logic [NM-1:0]    mask_q,     mask_d;
  logic [NVARS:0]   count_q,    count_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [NVARS-1:0] nxt_ptr_s;

  // Next-state logic; m_index_q doubles as the EMIT pointer so outputs stay registered.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    vars_out_d = vars_out_q;
    m_valid_d  = m_valid_q;
    m_index_d  = m_index_q;
    mask_d     = mask_q;
    count_d    = count_q;
    done_d     = 1'b0;
    nxt_ptr_s  = m_index_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d     = '0;
          count_d    = '0;
          idx_d      = '0;
          vars_out_d = '0;
          cnt_d      = SETTLE_LD;
          state_d    = ST_DRIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CW'(1)) begin
          // Sample on the last cycle of the hold window.
          mask_d[idx_q] = y_in;
          count_d       = count_q + {{NVARS{1'b0}}, y_in};
          if (idx_q == LAST_IDX) begin
            state_d   = ST_EMIT;
            m_index_d = '0;
            m_valid_d = mask_d[0];
          end else begin
            idx_d      = idx_q + 1'b1;
            vars_out_d = idx_q + 1'b1;
            cnt_d      = SETTLE_LD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_EMIT: begin
        if (!m_valid_q || m_ready) begin
          if (m_index_q == LAST_IDX) begin
            state_d    = ST_DONE;
            m_valid_d  = 1'b0;
            m_index_d  = '0;
            vars_out_d = '0;
            done_d     = 1'b1;
          end else begin
            m_index_d = nxt_ptr_s;
            m_valid_d = mask_q[nxt_ptr_s];
          end
        end else begin
          m_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_EMIT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      vars_out_q <= '0;
      m_valid_q  <= 1'b0;
      m_index_q  <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      vars_out_q <= vars_out_d;
      m_valid_q  <= m_valid_d;
      m_index_q  <= m_index_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign vars_out = vars_out_q;
  assign m_valid  = m_valid_q;
  assign m_index  = m_index_q;
  assign mask_out = mask_q;
  assign count    = count_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/minterm_scan.md
Name: minterm_scan

Overview:
Sequential truth-table extractor for small combinational SOP blocks. It sweeps every input combination into an external combinational function, samples that function's single output, and assembles a minterm mask. It then streams out the index of each set minterm over a valid/ready handshake. It is the inverse of an SOP block: function in, Σm list out. It is used as the self-checking front end for the team's combinational exercise modules.

Parameters:
NVARS, 4, number of function inputs; variable A is the MSB of the index.
SETTLE, 2, cycles each input vector is held before sampling y_in; legal range is 1 or more.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  reset, synchronous, active-high.
start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
vars_out  out  NVARS  input vector driven to the function under scan, {A,B,C,D} order.
y_in  in  1  function output, sampled at the end of each hold window.
m_valid  out  1  a minterm index is presented.
m_ready  in  1  consumer accepts the index.
m_index  out  NVARS  current minterm index.
mask_out  out  2**NVARS  bit i = 1 if minterm i is set; stable from DONE until the next accepted start.
count  out  NVARS+1  number of set minterms, popcount of mask_out.
busy  out  1  high in DRIVE and EMIT.
done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset: state goes to IDLE. vars_out, m_valid, m_index, mask_out, count, busy and done all go to 0. Reset takes priority in every state, including mid-DRIVE and mid-EMIT.
- States:
  - IDLE: start=1 clears mask_out and count, sets idx=0 and vars_out=0, loads the settle counter with SETTLE, then goes to DRIVE.
  - DRIVE: vars_out=idx. The settle counter decrements each cycle. On the cycle the counter reaches 1:
    - mask_out[idx] is set to y_in, and count increments if y_in=1.
    - If idx=2**NVARS-1, go to EMIT with ptr=0.
    - Otherwise idx increments and the counter reloads.
  - EMIT: scans one bit per cycle.
    - m_index=ptr and m_valid=mask_out[ptr].
    - If mask_out[ptr]=0, ptr advances.
    - If m_valid=1 and m_ready=1, the transfer completes and ptr advances.
    - If m_valid=1 and m_ready=0, ptr and m_index hold and m_valid stays 1 (no retraction).
    - Advancing past ptr=2**NVARS-1 goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. vars_out returns to 0.
- start is ignored outside IDLE. m_ready is ignored when m_valid=0.
- Indices are emitted in strictly ascending order, each set minterm exactly once.
- Latency with no stalls: start edge, then 1 edge to DRIVE, then 2**NVARS*SETTLE edges of DRIVE, then 2**NVARS edges of EMIT. done is high in the following cycle. For the defaults this is 1+32+16 = 49 edges after start. Each stall cycle adds exactly 1.
- count can reach 2**NVARS, hence its NVARS+1 width. Index counters wrap only through the explicit last-index check, never by overflow.

Decomposition:
- Shared package holds the state encoding (IDLE, DRIVE, EMIT, DONE) and the constant NMINTERMS = 2**NVARS.
- No sub-module is required. The settle counter and EMIT pointer are simple enough to stay inline.

Test Plan:
1. Reset: assert rst for 2 cycles with start=1 -> all outputs 0, state IDLE, no scan begins.
2. Function Σm(1,2,3,4) = !A!B D + !A!B C + !A B!C!D, m_ready=1, defaults -> mask_out=16'h001E, count=4. m_index sequence is 1,2,3,4, each valid one cycle. done pulses 49 edges after start.
3. Same function, m_ready low for 3 cycles while m_index=2 -> m_valid and m_index=2 held stable, no duplicate or skipped index, done 3 cycles later (52 edges).
4. Constant-0 function -> mask_out=0, count=0, m_valid never asserts, done at 49 edges. Constant-1 function -> mask_out=16'hFFFF, count=16 (5'b10000), indices 0..15 on consecutive cycles.
5. start pulsed again mid-DRIVE -> ignored, mask result unchanged. rst during EMIT -> next cycle all outputs 0 and IDLE; a fresh start then yields the correct result.
6. SETTLE=1 with a function whose y_in depends on vars_out through a 1-cycle register -> captured mask is the function shifted by one index. This confirms that sampling happens on the last hold cycle.
